// File: rtl/counter_updown_mod_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_updown_mod_if
// Purpose  : Control/status bundle for the up/down modulo counter.
// Revision : 1.0 - initial release
// ============================================================================
interface counter_updown_mod_if #(
  parameter int WIDTH = 4
);
  logic             i_en;
  logic             i_up;
  logic             i_oneshot;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic [WIDTH-1:0] o_out;
  logic             o_tc;
  logic             o_wrap;
  logic             o_done;

  // Master drives the controls; the counter is the slave.
  modport master (
    output i_en, i_up, i_oneshot, i_load, i_load_val,
    input  o_out, o_tc, o_wrap, o_done
  );

  modport slave (
    input  i_en, i_up, i_oneshot, i_load, i_load_val,
    output o_out, o_tc, o_wrap, o_done
  );
endinterface
`default_nettype wire

// File: rtl/counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module   : counter_updown_mod
// Purpose  : Up/down modulo-N counter with load, prescaler and one-shot mode.
// Revision : 1.0 - initial release
// ============================================================================
module counter_updown_mod #(
  parameter int WIDTH     = 4,
  parameter int MODULO    = 2**WIDTH,
  parameter int RESET_VAL = 0,
  parameter int PRESCALE  = 1
) (
  input  wire logic            i_clk,
  input  wire logic            i_reset,
  counter_updown_mod_if.slave  bus
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] C_RST = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
  localparam logic [WIDTH:0]   C_MOD = (WIDTH + 1)'(MODULO);

  if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
    $error("counter_updown_mod: WIDTH must be in 1..30");
  end
  if (MODULO < 2 || MODULO > 2**WIDTH) begin : g_bad_modulo
    $error("counter_updown_mod: MODULO must be in 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULO) begin : g_bad_reset
    $error("counter_updown_mod: RESET_VAL must be in 0..MODULO-1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_updown_mod: PRESCALE must be >= 1");
  end

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;
  logic             r_done;
  logic             w_tick;
  logic             w_at_term;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_load_clamped;

  // Prescaler: a tick is the last enabled cycle of each PRESCALE-long period.
  if (PRESCALE == 1) begin : g_no_psc
    assign w_tick = bus.i_en;
  end else begin : g_psc
    localparam int            PSC_W     = $clog2(PRESCALE);
    localparam logic [PSC_W-1:0] C_PSC_MAX = PSC_W'(PRESCALE - 1);
    localparam logic [PSC_W-1:0] C_PSC_ONE = PSC_W'(1);

    logic [PSC_W-1:0] r_psc;

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_psc <= '0;
      end else if (bus.i_load) begin
        r_psc <= '0;
      end else if (bus.i_en) begin
        r_psc <= (r_psc == C_PSC_MAX) ? '0 : r_psc + C_PSC_ONE;
      end
    end

    assign w_tick = bus.i_en && (r_psc == C_PSC_MAX);
  end

  assign w_term         = bus.i_up ? C_MAX : '0;
  assign w_at_term      = (r_out == w_term);
  assign w_load_clamped = ({1'b0, bus.i_load_val} >= C_MOD) ? C_MAX : bus.i_load_val;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out  <= C_RST;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else if (bus.i_load) begin
      r_out  <= w_load_clamped;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_tick) begin
        if (!w_at_term) begin
          r_out <= bus.i_up ? r_out + C_ONE : r_out - C_ONE;
        end else if (!bus.i_oneshot) begin
          r_out  <= bus.i_up ? '0 : C_MAX;
          r_wrap <= 1'b1;
        end else begin
          // One-shot: park at the terminal value and latch completion.
          r_done <= 1'b1;
        end
      end
    end
  end

  assign bus.o_out  = r_out;
  assign bus.o_tc   = w_at_term;
  assign bus.o_wrap = r_wrap;
  assign bus.o_done = r_done;

endmodule
`default_nettype wire
